// File: rtl/peck8_serializer.sv
// Byte-wide valid/ready to MSB-first serial transmitter with a programmable
// bit period (DIV clocks) and an inter-byte idle gap (GAP clocks).
module peck8_serializer #(
   parameter int DIV = 4,
   parameter int GAP = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       dout,
   output logic       dout_en,
   output logic       frame_done,
   output logic       busy
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [7:0]    GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bit_q, bit_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0]    gap_q, gap_d;

   logic din_ready_q, din_ready_d;
   logic dout_q, dout_d;
   logic dout_en_q, dout_en_d;
   logic frame_done_q, frame_done_d;
   logic busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      div_d   = div_q;
      gap_d   = gap_q;

      case (state_q)
         ST_IDLE: begin
            if (din_valid && din_ready_q) begin
               shreg_d = din;
               bit_d   = 3'd7;
               div_d   = DIV_LAST;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (div_q == '0) begin
               shreg_d = {shreg_q[6:0], 1'b0};
               div_d   = DIV_LAST;
               bit_d   = bit_q - 3'd1;
               if (bit_q == 3'd0) begin
                  if (GAP > 0) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_LAST;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               div_d = div_q - DW'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == 8'd0) state_d = ST_IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // NOTE: outputs are decoded from the next-state values so that the
      // registered copies line up with the state they describe, without
      // any combinational path from din_valid to a port.
      din_ready_d  = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      dout_d       = (state_d == ST_SHIFT) && shreg_d[7];
      dout_en_d    = (state_d == ST_SHIFT) && (div_d == '0);
      frame_done_d = dout_en_d && (bit_d == 3'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bit_q        <= '0;
         div_q        <= '0;
         gap_q        <= '0;
         din_ready_q  <= 1'b0;
         dout_q       <= 1'b0;
         dout_en_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_q        <= bit_d;
         div_q        <= div_d;
         gap_q        <= gap_d;
         din_ready_q  <= din_ready_d;
         dout_q       <= dout_d;
         dout_en_q    <= dout_en_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign din_ready  = din_ready_q;
   assign dout       = dout_q;
   assign dout_en    = dout_en_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_peck8_serializer.sv
// Bench for peck8_serializer: unit 0 runs DIV=4/GAP=2, unit 1 runs DIV=1/GAP=0.
// A cycle-timeline model checks every output; a deserializer scoreboard checks bytes.
module tb_peck8_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din       [2];
   logic       din_valid [2];
   logic       din_ready [2];
   logic       dout      [2];
   logic       dout_en   [2];
   logic       frame_done[2];
   logic       busy      [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      peck8_serializer #(
         .DIV((g == 0) ? 4 : 1),
         .GAP((g == 0) ? 2 : 0)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .din       (din[g]),
         .din_valid (din_valid[g]),
         .din_ready (din_ready[g]),
         .dout      (dout[g]),
         .dout_en   (dout_en[g]),
         .frame_done(frame_done[g]),
         .busy      (busy[g])
      );
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int u, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s unit%0d cycle %0d: got %0h, expected %0h", name, u, cyc, act, exp);
      end
   endtask

   // Scoreboard of bytes the downstream deserializer must end up holding.
   logic [7:0] sbq[2][$];

   // Timeline model state: accept cycle and byte of the frame in flight.
   bit         rst_edge = 1'b1;
   bit         active[2] = '{1'b0, 1'b0};
   int         acc[2];
   logic [7:0] abyte[2];
   logic [7:0] deser[2];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         int d, gp, t, k;
         logic [4:0] exp;
         d   = (u == 0) ? 4 : 1;
         gp  = (u == 0) ? 2 : 0;
         exp = '0;  // {din_ready, busy, dout, dout_en, frame_done}
         if (rst_edge) begin
            active[u] = 1'b0;
         end else if (active[u] && cyc <= acc[u] + 8 * d + gp) begin
            t = cyc - acc[u];
            exp[3] = 1'b1;
            if (t <= 8 * d) begin
               k = (t - 1) / d;
               exp[2] = abyte[u][7-k];
               exp[1] = (t % d == 0);
               exp[0] = (t == 8 * d);
            end
         end else begin
            active[u] = 1'b0;
            exp[4] = 1'b1;
         end
         check("outputs", u, 32'({din_ready[u], busy[u], dout[u], dout_en[u], frame_done[u]}),
               32'(exp));

         if (dout_en[u] === 1'b1) deser[u] = {deser[u][6:0], dout[u]};
         if (frame_done[u] === 1'b1) begin
            if (sbq[u].size() > 0) check("deser_byte", u, 32'(deser[u]), 32'(sbq[u].pop_front()));
            else                   check("spurious_frame", u, 32'(frame_done[u]), 32'd0);
         end

         if (exp[4] && din_valid[u] && rst_n) begin
            active[u] = 1'b1;
            acc[u]    = cyc;
            abyte[u]  = din[u];
         end
      end
      rst_edge = !rst_n;
   end

   task automatic present(input int u, input logic [7:0] b);
      din[u]       = b;
      din_valid[u] = 1'b1;
      sbq[u].push_back(b);
   endtask

   // Returns one posedge+1 after the accepting edge; c is the accepting cycle.
   task automatic wait_acc(input int u, output int c);
      c = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (din_valid[u] && din_ready[u] && rst_n) begin
            c = cyc;
            @(posedge clk);
            #1;
            return;
         end
      end
      check("accept_timeout", u, 32'(c), 32'(cyc));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int u, input logic [7:0] b, output int c);
      present(u, b);
      wait_acc(u, c);
      din_valid[u] = 1'b0;
   endtask

   task automatic wait_ready(input int u, output int r);
      r = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (din_ready[u]) begin
            r = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, r, rel, n;
      rst_n        = 1'b0;
      din[0]       = 8'hFF;
      din_valid[0] = 1'b1;
      din[1]       = 8'h00;
      din_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rel   = cyc;
      rst_n = 1'b1;
      sbq[0].push_back(8'hFF);
      wait_acc(0, c);
      din_valid[0] = 1'b0;
      check("accept_after_release", 0, 32'(c - rel), 32'd1);

      send(0, 8'hA5, c);
      wait_ready(0, r);
      check("ready_return", 0, 32'(r - c), 32'd35);

      present(0, 8'h3C);
      wait_acc(0, c);
      present(0, 8'hC3);
      wait_acc(0, c2);
      din_valid[0] = 1'b0;
      check("b2b_accept", 0, 32'(c2 - c), 32'd35);

      send(1, 8'h81, c);
      wait_ready(1, r);
      check("ready_return", 1, 32'(r - c), 32'd9);

      // Reset after the third strobe; the dropped byte leaves the scoreboard.
      send(0, 8'hF0, c);
      n = 0;
      for (int i = 0; i < 200 && n < 3; i++) begin
         @(negedge clk);
         if (dout_en[0]) n++;
      end
      check("strobes_before_reset", 0, 32'(n), 32'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(sbq[0].pop_back());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(0, 8'h0F, c);
      wait_ready(0, r);

      // Valid held high with din churning while the block is busy.
      send(0, 8'h6B, c);
      for (int i = 0; i < 200; i++) begin
         if (din_ready[0]) break;
         din[0]       = 8'($urandom);
         din_valid[0] = 1'b1;
         @(posedge clk);
         #1;
      end
      din_valid[0] = 1'b0;
      wait_ready(0, r);

      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(u, 8'($urandom), c);
         end
         wait_ready(u, r);
      end

      repeat (4) @(posedge clk);
      #1;
      check("sb_drained", 0, 32'(sbq[0].size()), 32'd0);
      check("sb_drained", 1, 32'(sbq[1].size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
